tug_war_scorer: RTL and testbench

// Multi-round match scorer for the tug-of-war lab. Watches the playfield light bar
// and the two player buttons, and awards a point when the active edge light is

---
 rtl/tug_war_scorer.sv | 127 ++++++++++++
 tb/tb_tug_war_scorer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tug_war_scorer.sv
// Tug-of-war match scorer: awards points when an edge light is pushed off, pulses a re-centre, latches the winner.
// Optional AUTO_RESTART_EN: pressing L and R together in DONE starts a fresh match.
module tug_war_scorer #(
  parameter int NLIGHTS   = 9,
  parameter int MAX_SCORE = 7,
  parameter int SCORE_W   = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               L,
  input  logic               R,
  input  logic [NLIGHTS-1:0] lights,
  output logic               round_clr,
  output logic [6:0]         hex_l,
  output logic [6:0]         hex_r,
  output logic               match_over,
  output logic [1:0]         winner
);

  typedef enum logic [1:0] {PLAY, CLEAR, DONE} state_t;

  localparam logic [SCORE_W-1:0] MAX_Q = SCORE_W'(MAX_SCORE);

  state_t               state_q;
  logic [SCORE_W-1:0]   scoreL_q;
  logic [SCORE_W-1:0]   scoreR_q;
  logic                 roundClr_q;
  logic                 matchOver_q;
  logic [1:0]           winner_q;

  logic                 rWin;
  logic                 lWin;
  logic [SCORE_W-1:0]   scoreL_d;
  logic [SCORE_W-1:0]   scoreR_d;

  // Only the two edge lights decide a point; the interior of the bar is not used here.
  logic                 unusedLights;
  assign unusedLights = ^lights[NLIGHTS-2:1];

  function automatic logic [6:0] hexDigit(input logic [SCORE_W-1:0] value);
    logic [6:0] seg;
    case (32'(value))
      0:       seg = 7'b1000000;
      1:       seg = 7'b1111001;
      2:       seg = 7'b0100100;
      3:       seg = 7'b0110000;
      4:       seg = 7'b0011001;
      5:       seg = 7'b0010010;
      6:       seg = 7'b0000010;
      7:       seg = 7'b1111000;
      8:       seg = 7'b0000000;
      9:       seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  always_comb begin
    rWin     = lights[0] & R & ~L;
    lWin     = lights[NLIGHTS-1] & L & ~R;
    scoreL_d = scoreL_q + 1'b1;
    scoreR_d = scoreR_q + 1'b1;
  end

  // Scoring FSM; the re-centre pulse defaults low and is raised only for one cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= PLAY;
      scoreL_q    <= '0;
      scoreR_q    <= '0;
      roundClr_q  <= 1'b0;
      matchOver_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      roundClr_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (rWin) begin
            scoreR_q <= scoreR_d;
            if (scoreR_d == MAX_Q) begin
              state_q     <= DONE;
              matchOver_q <= 1'b1;
              winner_q    <= 2'b01;
            end else begin
              state_q    <= CLEAR;
              roundClr_q <= 1'b1;
            end
          end else if (lWin) begin
            scoreL_q <= scoreL_d;
            if (scoreL_d == MAX_Q) begin
              state_q     <= DONE;
              matchOver_q <= 1'b1;
              winner_q    <= 2'b10;
            end else begin
              state_q    <= CLEAR;
              roundClr_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state_q     <= PLAY;
          matchOver_q <= 1'b0;
        end
        DONE: begin
`ifdef AUTO_RESTART_EN
          // match_over stays up through the restart's CLEAR cycle and drops on return to PLAY.
          if (L & R) begin
            state_q    <= CLEAR;
            scoreL_q   <= '0;
            scoreR_q   <= '0;
            winner_q   <= 2'b00;
            roundClr_q <= 1'b1;
          end
`endif
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  assign round_clr  = roundClr_q;
  assign match_over = matchOver_q;
  assign winner     = winner_q;
  assign hex_l      = hexDigit(scoreL_q);
  assign hex_r      = hexDigit(scoreR_q);

endmodule

// File: tb/tb_tug_war_scorer.sv
// Randomized self-checking bench for tug_war_scorer against a score-counting reference model.
module tb_tug_war_scorer;

  localparam int NLIGHTS   = 9;
  localparam int MAX_SCORE = 7;

  logic               Clock;
  logic               Reset;
  logic               L;
  logic               R;
  logic [NLIGHTS-1:0] lights;
  logic               round_clr;
  logic [6:0]         hex_l;
  logic [6:0]         hex_r;
  logic               match_over;
  logic [1:0]         winner;

  int checks = 0;
  int errors = 0;

  int mScoreL, mScoreR, mWinner;
  bit mClr, mOver;

  tug_war_scorer #(.NLIGHTS(NLIGHTS), .MAX_SCORE(MAX_SCORE), .SCORE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .L(L), .R(R), .lights(lights),
    .round_clr(round_clr), .hex_l(hex_l), .hex_r(hex_r),
    .match_over(match_over), .winner(winner)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [6:0] expHex(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, then compare all outputs.
  task automatic applyStimulus(input bit rst, input bit l, input bit r, input logic [NLIGHTS-1:0] lt);
    Reset  = rst;
    L      = l;
    R      = r;
    lights = lt;
    @(posedge Clock);
    if (rst) begin
      mScoreL = 0; mScoreR = 0; mWinner = 0; mClr = 0; mOver = 0;
    end else if (mClr) begin
      mClr  = 0;
      mOver = 0;
    end else if (mOver) begin
`ifdef AUTO_RESTART_EN
      if (l && r) begin
        mScoreL = 0; mScoreR = 0; mWinner = 0; mClr = 1;
      end
`endif
    end else if (lt[0] && r && !l) begin
      mScoreR++;
      if (mScoreR == MAX_SCORE) begin mOver = 1; mWinner = 1; end
      else mClr = 1;
    end else if (lt[NLIGHTS-1] && l && !r) begin
      mScoreL++;
      if (mScoreL == MAX_SCORE) begin mOver = 1; mWinner = 2; end
      else mClr = 1;
    end
    #1;
    checkOutput("round_clr", 32'(round_clr), 32'(mClr));
    checkOutput("match_over", 32'(match_over), 32'(mOver));
    checkOutput("winner", 32'(winner), 32'(mWinner));
    checkOutput("hex_l", 32'(hex_l), 32'(expHex(mScoreL)));
    checkOutput("hex_r", 32'(hex_r), 32'(expHex(mScoreR)));
  endtask

  localparam logic [NLIGHTS-1:0] RIGHT_EDGE = 9'b000000001;
  localparam logic [NLIGHTS-1:0] LEFT_EDGE  = 9'b100000000;
  localparam logic [NLIGHTS-1:0] CENTRE     = 9'b000010000;

  initial begin
    logic [NLIGHTS-1:0] lt;
    mScoreL = 0; mScoreR = 0; mWinner = 0; mClr = 0; mOver = 0;

    // Reset and idle
    applyStimulus(1, 0, 0, CENTRE);
    repeat (5) applyStimulus(0, 0, 0, CENTRE);

    // Right point, then the CLEAR cycle with a press that must be lost
    applyStimulus(0, 0, 1, RIGHT_EDGE);
    applyStimulus(0, 0, 1, RIGHT_EDGE);
    applyStimulus(0, 0, 0, CENTRE);

    // Simultaneous presses at the left edge never score
    applyStimulus(0, 1, 1, LEFT_EDGE);
    applyStimulus(0, 0, 0, CENTRE);

    // Press without the edge light lit
    applyStimulus(0, 1, 0, CENTRE);

    // Right player runs the match to MAX_SCORE
    while (!mOver) begin
      applyStimulus(0, 0, 1, RIGHT_EDGE);
      applyStimulus(0, 0, 0, CENTRE);
    end
    repeat (3) applyStimulus(0, 0, 1, RIGHT_EDGE);
    repeat (3) applyStimulus(0, 1, 0, LEFT_EDGE);
    applyStimulus(0, 1, 1, LEFT_EDGE | RIGHT_EDGE);
    applyStimulus(0, 0, 0, CENTRE);

    // Reset out of DONE, then a left-player match
    applyStimulus(1, 0, 0, CENTRE);
    repeat (MAX_SCORE) begin
      applyStimulus(0, 1, 0, LEFT_EDGE);
      applyStimulus(0, 0, 0, CENTRE);
    end
    applyStimulus(0, 1, 0, LEFT_EDGE);
    applyStimulus(1, 0, 0, CENTRE);

    // Reset landing on a CLEAR cycle suppresses the pulse
    applyStimulus(0, 0, 1, RIGHT_EDGE);
    applyStimulus(1, 0, 0, CENTRE);

    // Random play with edge-biased light patterns and occasional resets
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: lt = RIGHT_EDGE;
        1: lt = LEFT_EDGE;
        2: lt = NLIGHTS'(1) << $urandom_range(0, NLIGHTS - 1);
        default: lt = NLIGHTS'($urandom);
      endcase
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 35, lt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
